// File: rtl/dsi_dphy_pkg.sv
// Shared D-PHY lane definitions: sequencer states, sync byte, LP line levels.
package dsi_dphy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LP_RQST,
        ST_LP_PREP,
        ST_HS_ZERO,
        ST_HS_SYNC,
        ST_HS_DATA,
        ST_HS_TRAIL,
        ST_HS_EXIT
    } lane_state_t;

    localparam logic [7:0] c_dphy_sync_byte = 8'hB8;

    // LP levels packed as {p, n}
    localparam logic [1:0] c_lp_11 = 2'b11;
    localparam logic [1:0] c_lp_01 = 2'b01;
    localparam logic [1:0] c_lp_00 = 2'b00;

    // Timer preset for a duration of t cycles; a zero duration behaves as one cycle.
    function automatic int unsigned timer_preset(input int unsigned t);
        return (t == 32'd0) ? 32'd0 : t - 32'd1;
    endfunction

endpackage

// File: rtl/dphy_lane_timer.sv
// Loadable down-counter with a zero flag; shared by the data and clock lane sequencers.
module dphy_lane_timer #(
    parameter int unsigned g_cnt_width = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [g_cnt_width-1:0] load_value,
    output logic                   zero_c
);

    logic [g_cnt_width-1:0] count;

    // Saturates at zero so a state that ignores the timer leaves it idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - g_cnt_width'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/dphy_data_lane_ctrl.sv
// D-PHY data lane transmit sequencer: LP request/prepare, HS zero/sync/payload/trail, LP exit.
module dphy_data_lane_ctrl
    import dsi_dphy_pkg::*;
#(
    parameter int unsigned g_t_lpx        = 2,
    parameter int unsigned g_t_hs_prepare = 2,
    parameter int unsigned g_t_hs_zero    = 6,
    parameter int unsigned g_t_hs_trail   = 4,
    parameter int unsigned g_t_hs_exit    = 6,
    parameter int unsigned g_cnt_width    = 8
) (
    input  logic       clk_word_i,
    input  logic       rst_n_a_i,
    input  logic       hs_req_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       busy_o,
    output logic [7:0] d_o,
    output logic       hs_t_o,
    output logic       lp_oe_n_o,
    output logic       lp_p_o,
    output logic       lp_n_o
);

    localparam logic [g_cnt_width-1:0] c_ld_lpx   = g_cnt_width'(timer_preset(g_t_lpx));
    localparam logic [g_cnt_width-1:0] c_ld_prep  = g_cnt_width'(timer_preset(g_t_hs_prepare));
    localparam logic [g_cnt_width-1:0] c_ld_zero  = g_cnt_width'(timer_preset(g_t_hs_zero));
    localparam logic [g_cnt_width-1:0] c_ld_trail = g_cnt_width'(timer_preset(g_t_hs_trail));
    localparam logic [g_cnt_width-1:0] c_ld_exit  = g_cnt_width'(timer_preset(g_t_hs_exit));

    lane_state_t            state;
    lane_state_t            state_nxt;
    logic                   tmr_load;
    logic [g_cnt_width-1:0] tmr_value;
    logic                   tmr_zero;

    dphy_lane_timer #(
        .g_cnt_width(g_cnt_width)
    ) u_timer (
        .clk        (clk_word_i),
        .rst_n      (rst_n_a_i),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero_c     (tmr_zero)
    );

    assign tx_ready_o = (state == ST_HS_SYNC) || (state == ST_HS_DATA);

    // Next state and timer preset on each state entry.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ST_IDLE: if (hs_req_i) begin
                state_nxt = ST_LP_RQST;
                tmr_load  = 1'b1;
                tmr_value = c_ld_lpx;
            end
            ST_LP_RQST: if (tmr_zero) begin
                state_nxt = ST_LP_PREP;
                tmr_load  = 1'b1;
                tmr_value = c_ld_prep;
            end
            ST_LP_PREP: if (tmr_zero) begin
                state_nxt = ST_HS_ZERO;
                tmr_load  = 1'b1;
                tmr_value = c_ld_zero;
            end
            ST_HS_ZERO: if (tmr_zero) begin
                state_nxt = ST_HS_SYNC;
            end
            ST_HS_SYNC, ST_HS_DATA: if (tx_valid_i) begin
                state_nxt = ST_HS_DATA;
            end else begin
                state_nxt = ST_HS_TRAIL;
                tmr_load  = 1'b1;
                tmr_value = c_ld_trail;
            end
            ST_HS_TRAIL: if (tmr_zero) begin
                state_nxt = ST_HS_EXIT;
                tmr_load  = 1'b1;
                tmr_value = c_ld_exit;
            end
            ST_HS_EXIT: if (tmr_zero) begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
        if (!rst_n_a_i) begin
            state              <= ST_IDLE;
            busy_o             <= 1'b0;
            d_o                <= 8'h00;
            hs_t_o             <= 1'b1;
            lp_oe_n_o          <= 1'b0;
            {lp_p_o, lp_n_o}   <= c_lp_11;
        end else begin
            state              <= state_nxt;
            busy_o             <= (state_nxt != ST_IDLE);
            d_o                <= 8'h00;
            hs_t_o             <= 1'b1;
            lp_oe_n_o          <= 1'b0;
            {lp_p_o, lp_n_o}   <= c_lp_11;
            case (state_nxt)
                ST_LP_RQST: {lp_p_o, lp_n_o} <= c_lp_01;
                ST_LP_PREP: {lp_p_o, lp_n_o} <= c_lp_00;
                ST_HS_ZERO, ST_HS_SYNC, ST_HS_DATA, ST_HS_TRAIL: begin
                    hs_t_o           <= 1'b0;
                    lp_oe_n_o        <= 1'b1;
                    {lp_p_o, lp_n_o} <= c_lp_00;
                end
                default: ;
            endcase
            case (state_nxt)
                ST_HS_SYNC: d_o <= c_dphy_sync_byte;
                ST_HS_DATA: d_o <= tx_data_i;
                // Trail is the inverse of the last transmitted bit, latched on entry.
                ST_HS_TRAIL: d_o <= (state == ST_HS_TRAIL) ? d_o : (d_o[7] ? 8'h00 : 8'hFF);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dphy_data_lane_ctrl.sv
// Directed bench for the D-PHY data lane sequencer with hand-derived per-cycle expectations.
module tb_dphy_data_lane_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hs_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic [7:0] d;
    logic       hs_t;
    logic       lp_oe_n;
    logic       lp_p;
    logic       lp_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [13:0] exp_q[$];
    logic [13:0] obs_q[$];
    bit          req_q[$];
    bit          vld_q[$];
    logic [7:0]  dat_q[$];

    always #5 clk = ~clk;

    dphy_data_lane_ctrl dut (
        .clk_word_i (clk),
        .rst_n_a_i  (rst_n),
        .hs_req_i   (hs_req),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .busy_o     (busy),
        .d_o        (d),
        .hs_t_o     (hs_t),
        .lp_oe_n_o  (lp_oe_n),
        .lp_p_o     (lp_p),
        .lp_n_o     (lp_n)
    );

    // Observation word: {d[13:6], hs_t[5], lp_oe_n[4], lp_p[3], lp_n[2], busy[1], tx_ready[0]}
    function automatic logic [13:0] obs();
        return {d, hs_t, lp_oe_n, lp_p, lp_n, busy, tx_ready};
    endfunction

    function automatic logic [13:0] mk(input logic [7:0] dv, input logic t, input logic oe_n,
                                       input logic [1:0] lp, input logic bz, input logic rdy);
        return {dv, t, oe_n, lp, bz, rdy};
    endfunction

    localparam logic [13:0] E_IDLE = {8'h00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0};
    localparam logic [13:0] E_RQST = {8'h00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
    localparam logic [13:0] E_PREP = {8'h00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
    localparam logic [13:0] E_EXIT = {8'h00, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0};

    task automatic clear_seq();
        exp_q.delete(); obs_q.delete(); req_q.delete(); vld_q.delete(); dat_q.delete();
    endtask

    // Appends one burst with default timing; entry j is the lane state right after edge j.
    task automatic build_burst(input logic [7:0] b[$], input bit hold);
        int n;
        logic [7:0] last;
        logic [7:0] trail;
        n = b.size();
        last = 8'hB8;
        if (n > 0) last = b[n-1];
        trail = last[7] ? 8'h00 : 8'hFF;
        for (int j = 0; j < 22 + n; j++) begin
            if (j < 2)                exp_q.push_back(E_RQST);
            else if (j < 4)           exp_q.push_back(E_PREP);
            else if (j < 10)          exp_q.push_back(mk(8'h00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0));
            else if (j == 10)         exp_q.push_back(mk(8'hB8, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1));
            else if (j <= 10 + n)     exp_q.push_back(mk(b[j-11], 1'b0, 1'b1, 2'b00, 1'b1, 1'b1));
            else if (j <= 14 + n)     exp_q.push_back(mk(trail, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0));
            else if (j <= 20 + n)     exp_q.push_back(E_EXIT);
            else                      exp_q.push_back(E_IDLE);
            req_q.push_back(hold || (j == 0));
            vld_q.push_back((j >= 11) && (j < 11 + n));
            dat_q.push_back(((j >= 11) && (j < 11 + n)) ? b[j-11] : 8'h00);
        end
    endtask

    // Applies scheduled inputs for each edge and records outputs #1 after it.
    task automatic run_seq(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            hs_req   = req_q[k];
            tx_valid = vld_q[k];
            tx_data  = dat_q[k];
            @(posedge clk); #1;
            obs_q.push_back(obs());
        end
        hs_req = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs() !== E_IDLE) begin
                n_err++;
                $display("FAIL reset_hold: got %h expected %h", obs(), E_IDLE);
            end
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs() !== E_IDLE) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got %h expected %h", k, obs(), E_IDLE);
            end
        end
    endtask

    task automatic test_default_burst();
        logic [7:0] q[$];
        q = {8'h12, 8'h34, 8'h80};
        clear_seq();
        build_burst(q, 1'b0);
        run_seq(exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL default_burst[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_trail_polarity();
        logic [7:0] q[$];
        int nff;
        q = {8'h01, 8'h7F};
        clear_seq();
        build_burst(q, 1'b0);
        run_seq(exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL trail_polarity[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]);
            end
        end
        nff = 0;
        for (int k = 13; k <= 16; k++) if (obs_q[k][13:6] === 8'hFF) nff++;
        n_cmp++;
        if (nff != 4) begin
            n_err++;
            $display("FAIL trail_ff_count: got %0d expected 4", nff);
        end
    endtask

    task automatic test_empty_burst();
        logic [7:0] q[$];
        clear_seq();
        build_burst(q, 1'b0);
        run_seq(exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_err++;
                $display("FAIL empty_burst[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid_payload();
        logic [7:0] q[$];
        q = {8'h55, 8'hAA, 8'h33};
        clear_seq();
        build_burst(q, 1'b0);
        run_seq(13);
        n_cmp++;
        if (obs_q[12] !== exp_q[12]) begin
            n_err++;
            $display("FAIL mid_payload_byte2: got %h expected %h", obs_q[12], exp_q[12]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== E_IDLE) begin
            n_err++;
            $display("FAIL mid_reset_async: got %h expected %h", obs(), E_IDLE);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs() !== E_IDLE) begin
                n_err++;
                $display("FAIL mid_reset_after[%0d]: got %h expected %h", k, obs(), E_IDLE);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int nlp11;
        int k;
        clear_seq();
        q = {8'hC3};
        build_burst(q, 1'b1);
        q = {8'h3C};
        build_burst(q, 1'b1);
        run_seq(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        // First burst's last trail byte sits at index 15; count LP-11 until the next LP-01.
        nlp11 = 0;
        k = 16;
        while (k < obs_q.size() && obs_q[k][3:2] === 2'b11) begin
            nlp11++;
            k++;
        end
        n_cmp++;
        if (nlp11 != 7 || k >= obs_q.size() || obs_q[k][3:2] !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_lp11_gap: got %0d cycles expected 7 followed by LP-01", nlp11);
        end
    endtask

    initial begin
        test_reset();
        test_default_burst();
        test_trail_polarity();
        test_empty_burst();
        test_reset_mid_payload();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dphy_data_lane_ctrl.md
Name: dphy_data_lane_ctrl

Overview:
- Per-lane D-PHY transmit sequencer in the word-clock domain, directly upstream of the lane SerDes (dphy_serdes_spartan6 / dphy_serdes_zynq).
- Takes a byte stream and produces, each word clock:
  - the 8-bit parallel HS word;
  - the HS tristate control;
  - LP line levels and the LP driver enable.
- Sequences one HS burst: LP-11 → LP-01 → LP-00 → HS-zero → sync → payload → trail → LP-11.
- The clock lane is not handled here.

Parameters:
- g_t_lpx, 2, word clocks in LP-01 (request)
- g_t_hs_prepare, 2, word clocks in LP-00 (prepare)
- g_t_hs_zero, 6, word clocks of HS 0x00 before sync
- g_t_hs_trail, 4, word clocks of trail bytes
- g_t_hs_exit, 6, word clocks of LP-11 before the next request is accepted
- g_cnt_width, 8, timer width; all timing values are < 2^g_cnt_width

Ports:
- clk_word_i, in, 1: word (byte) clock, same clock as the SerDes clk_word_i
- rst_n_a_i, in, 1: asynchronous, active-low reset
- hs_req_i, in, 1: level; start a burst when sampled high in IDLE
- tx_data_i, in, 8: payload byte; bit 0 goes on the wire first
- tx_valid_i, in, 1: payload byte valid
- tx_ready_o, out, 1: byte accepted when tx_valid_i & tx_ready_o
- busy_o, out, 1: high in every state except IDLE
- d_o, out, 8: to SerDes d_i
- hs_t_o, out, 1: to SerDes oe_i; OSERDES T semantics, 1 = HS high-Z, 0 = driving
- lp_oe_n_o, out, 1: LP driver enable, active-low
- lp_p_o, out, 1: LP level, P line
- lp_n_o, out, 1: LP level, N line

Behaviour:
- Single clock, clk_word_i. Reset is asynchronous, active-low (rst_n_a_i).
- All outputs are registered, except tx_ready_o, which is decoded from state.
- Reset values: d_o=0x00, hs_t_o=1, lp_oe_n_o=0, lp_p_o=1, lp_n_o=1, busy_o=0, tx_ready_o=0; state=IDLE; timer=0.
- Reset asserted mid-burst:
  - immediately forces the reset values (lane returns to LP-11, HS tristated);
  - any partial burst is dropped;
  - no trail is sent.
- Timer: loads (param−1) on state entry, decrements, and the state exits when timer==0. A parameter value of 0 behaves as 1.
- States and outputs (d_o / hs_t_o / lp_oe_n_o / lp_p_o,lp_n_o):
  - IDLE: 0x00 / 1 / 0 / 1,1. Goes to LP_RQST when hs_req_i=1.
  - LP_RQST: 0x00 / 1 / 0 / 0,1. Lasts g_t_lpx cycles, then LP_PREP.
  - LP_PREP: 0x00 / 1 / 0 / 0,0. Lasts g_t_hs_prepare cycles, then HS_ZERO.
  - HS_ZERO: 0x00 / 0 / 1 / 0,0. Lasts g_t_hs_zero cycles, then HS_SYNC.
  - HS_SYNC: 0xB8 / 0 / 1 / 0,0. Lasts exactly 1 cycle. tx_ready_o=1.
    - If a byte is accepted: HS_DATA.
    - Otherwise: HS_TRAIL (empty burst).
  - HS_DATA: accepted byte / 0 / 1 / 0,0. tx_ready_o=1.
    - Each accepted byte appears on d_o on the next cycle (1-cycle latency).
    - Stays while tx_valid_i=1.
    - The first cycle with tx_valid_i=0 goes to HS_TRAIL.
  - HS_TRAIL: trail byte / 0 / 1 / 0,0. Lasts g_t_hs_trail cycles, then HS_EXIT.
    - Trail byte is 0xFF if bit 7 of the last transmitted byte was 0, else 0x00.
    - After a sync-only burst, the last byte is 0xB8 (bit 7 = 1), so the trail is 0x00.
  - HS_EXIT: 0x00 / 1 / 0 / 1,1. Lasts g_t_hs_exit cycles, then IDLE.
- tx_ready_o is 0 in all states other than HS_SYNC and HS_DATA.
- The payload must be gap-free. A deasserted tx_valid_i inside HS_DATA ends the burst; the source must not resume valid afterwards.
- hs_req_i is ignored outside IDLE.
- If hs_req_i is held high, a new burst starts in the first IDLE cycle after HS_EXIT, i.e. LP-11 lasts exactly g_t_hs_exit+1 cycles.
- Transmitting 0xB8 in LSB-first order yields the D-PHY sync sequence 00011101.

Decomposition:
- Shared package dsi_dphy_pkg holds:
  - the state enum;
  - c_dphy_sync_byte = 8'hB8;
  - LP level constants for LP-11, LP-01 and LP-00.
- One natural sub-module: dphy_lane_timer, a loadable down-counter with a zero flag, sized g_cnt_width. It is shared later with the clock-lane controller.

Test Plan:
- Reset then idle:
  - Hold rst_n_a_i low 5 cycles, release, keep hs_req_i=0 for 20 cycles.
  - Required: lp=1,1, lp_oe_n_o=0, hs_t_o=1, d_o=0x00, busy_o=0 throughout.
- Default-timing burst of 3 bytes:
  - Pulse hs_req_i, stream 0x12, 0x34, 0x80 contiguously.
  - Required: LP-01 for 2 cycles, LP-00 for 2, 0x00 for 6, then 0xB8, 0x12, 0x34, 0x80.
  - Then trail 0x00×4 (bit 7 of 0x80 is 1), LP-11 for 6, then busy_o=0.
- Trail polarity:
  - Send a burst whose last byte is 0x7F.
  - Required: four trail bytes of 0xFF.
- Empty burst:
  - Request with tx_valid_i=0.
  - Required: a single 0xB8, then 0x00×4 trail, then exit.
- Reset mid-payload:
  - Assert rst_n_a_i during the 2nd payload byte.
  - Required: in the same cycle hs_t_o=1 and lp=1,1; after release, state is IDLE with no trail emitted.
- Back-to-back:
  - Hold hs_req_i=1 across two 1-byte bursts.
  - Required: exactly 7 LP-11 cycles between the last trail byte and the second LP-01.
